// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

    localparam int unsigned IMEM_ADDR_W = 10;
    localparam int unsigned IMEM_DEPTH  = 1024;

    // Must match the instruction receiver's halt opcode.
    localparam logic [31:0] TERM_WORD = 32'h0000_0000;

    // Value written to PC before a run.
    localparam logic [31:0] PC_START = 32'h0000_0000;

    typedef enum logic [3:0] {
        S_LEN_HI  = 4'd0,
        S_LEN_LO  = 4'd1,
        S_DATA    = 4'd2,
        S_CSUM    = 4'd3,
        S_TERM    = 4'd4,
        S_PC_CLR  = 4'd5,
        S_RUN     = 4'd6,
        S_RELEASE = 4'd7,
        S_ERR     = 4'd8
    } state_t;

    // A length is accepted when it is a non-zero whole number of words within max_len.
    function automatic logic len_valid(input logic [15:0] len, input logic [16:0] max_len);
        return (len >= 16'd4) && ({1'b0, len} <= max_len) && (len[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Receives a framed program byte stream, loads it into instruction memory,
// appends a zero terminator, clears PC and hands control to the receiver.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = IMEM_ADDR_W,
    parameter int unsigned MAX_LEN = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [7:0]        imem_wdata,
    output logic              imem_wren,
    output logic [31:0]       pc_wdata,
    output logic              pc_wren,
    output logic              go,
    input  logic              finish,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);

    localparam int unsigned PTR_W     = ADDR_W + 1;
    localparam int unsigned DEPTH     = 32'(1) << ADDR_W;
    localparam logic [16:0] LAST_ADDR = 17'(DEPTH - 1);

    state_t            state, state_nx;
    logic [15:0]       len, len_nx;
    logic [PTR_W-1:0]  ptr, ptr_nx;
    logic [7:0]        sum, sum_nx;
    logic              wren_nx;
    logic [ADDR_W-1:0] waddr_nx;
    logic [7:0]        wdata_nx;
    logic              pc_wren_nx;
    logic              go_nx;
    logic              xfer;
    logic              term_skip;

    assign xfer      = rx_valid & rx_ready;
    // Terminator would run past the top of memory, so it is dropped.
    assign term_skip = (17'(len) + 17'd3) > LAST_ADDR;
    assign pc_wdata  = PC_START;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_LEN_HI;
        else        state <= state_nx;
    end

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_nx   = state;
        len_nx     = len;
        ptr_nx     = ptr;
        sum_nx     = sum;
        wren_nx    = 1'b0;
        waddr_nx   = imem_waddr;
        wdata_nx   = imem_wdata;
        pc_wren_nx = 1'b0;
        go_nx      = 1'b0;

        case (state)
            S_LEN_HI: begin
                if (xfer) begin
                    len_nx   = {rx_data, len[7:0]};
                    state_nx = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_nx   = {len[15:8], rx_data};
                    ptr_nx   = '0;
                    sum_nx   = 8'h00;
                    state_nx = len_valid(len_nx, 17'(MAX_LEN)) ? S_DATA : S_ERR;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    wren_nx  = 1'b1;
                    waddr_nx = ptr[ADDR_W-1:0];
                    wdata_nx = rx_data;
                    ptr_nx   = ptr + PTR_W'(1);
                    sum_nx   = sum + rx_data;
                    if (ptr == PTR_W'(len - 16'd1)) state_nx = S_CSUM;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (rx_data != sum) state_nx = S_ERR;
                    else if (term_skip) state_nx = S_PC_CLR;
                    else                state_nx = S_TERM;
                end
            end
            S_TERM: begin
                // ptr starts at LEN (word aligned), so its low bits index the terminator byte.
                wren_nx  = 1'b1;
                waddr_nx = ptr[ADDR_W-1:0];
                wdata_nx = TERM_WORD[{ptr[1:0], 3'b000} +: 8];
                ptr_nx   = ptr + PTR_W'(1);
                if (ptr[1:0] == 2'd3) state_nx = S_PC_CLR;
            end
            S_PC_CLR: begin
                pc_wren_nx = 1'b1;
                state_nx   = S_RUN;
            end
            S_RUN: begin
                if (finish) state_nx = S_RELEASE;
                else        go_nx    = 1'b1;
            end
            S_RELEASE: begin
                if (!finish) state_nx = S_LEN_HI;
            end
            S_ERR: begin
                if (err_clr) state_nx = S_LEN_HI;
            end
            default: state_nx = S_LEN_HI;
        endcase
    end

    // Datapath and output registers; status outputs follow the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len        <= 16'h0000;
            ptr        <= '0;
            sum        <= 8'h00;
            rx_ready   <= 1'b1;
            imem_wren  <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= 8'h00;
            pc_wren    <= 1'b0;
            go         <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            len        <= len_nx;
            ptr        <= ptr_nx;
            sum        <= sum_nx;
            rx_ready   <= (state_nx == S_LEN_HI) || (state_nx == S_LEN_LO) ||
                          (state_nx == S_DATA)   || (state_nx == S_CSUM);
            imem_wren  <= wren_nx;
            imem_waddr <= waddr_nx;
            imem_wdata <= wdata_nx;
            pc_wren    <= pc_wren_nx;
            go         <= go_nx;
            busy       <= (state_nx != S_LEN_HI) && (state_nx != S_ERR);
            err        <= (state_nx == S_ERR);
        end
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Upstream stage of the instruction receiver. Accepts a framed program as a byte stream (length header, payload, checksum) and writes it into the byte-wide instruction memory. It appends a zero-word terminator, clears PC to 0, then raises `go` and holds it until the receiver reports `finish`. After that handshake it returns to waiting for the next frame.

## Interface
Parameters:
- `ADDR_W`, 10: instruction memory address width; depth = 2^ADDR_W bytes.
- `MAX_LEN`, 1024: largest accepted payload length in bytes; must be ≤ 2^ADDR_W.

Ports:
- `clk`  in  1: the single clock. All logic is on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `rx_data`  in  8: incoming stream byte.
- `rx_valid`  in  1: `rx_data` is valid this cycle.
- `rx_ready`  out  1: loader accepts a byte this cycle. A transfer happens when `rx_valid & rx_ready` at the clock edge.
- `imem_waddr`  out  ADDR_W: instruction memory write address.
- `imem_wdata`  out  8: instruction memory write byte.
- `imem_wren`  out  1: instruction memory write strobe.
- `pc_wdata`  out  32: PC write value; always 0.
- `pc_wren`  out  1: PC write strobe.
- `go`  out  1: run request to the instruction receiver.
- `finish`  in  1: receiver has hit a zero instruction.
- `busy`  out  1: high in every state except LEN_HI and ERR.
- `err`  out  1: a frame was rejected; sticky until `err_clr`.
- `err_clr`  in  1: leave ERR.

## Operation
Frame format: `LEN[15:8]`, `LEN[7:0]`, `LEN` payload bytes, then `CSUM`. `CSUM` is the sum of the payload bytes mod 256; the length bytes are not included.

FSM states:
- LEN_HI: `rx_ready`=1. On a transfer, latch the high length byte and go to LEN_LO.
- LEN_LO: `rx_ready`=1. On a transfer, latch the low byte and validate the length.
  - Valid when 4 ≤ LEN ≤ MAX_LEN and LEN[1:0]=0.
  - Invalid → ERR. Valid → DATA, with write pointer and sum cleared to 0.
- DATA: `rx_ready`=1. Each transfer writes the byte at the pointer, adds it to the 8-bit sum (wrapping), and increments the pointer. After byte LEN−1 → CSUM.
- CSUM: `rx_ready`=1. On a transfer, compare with the sum. Mismatch → ERR; match → TERM.
- TERM: `rx_ready`=0.
  - Writes `8'h00` at addresses LEN..LEN+3, one byte per cycle, then → PC_CLR.
  - If LEN+3 > 2^ADDR_W−1, the writes are skipped and the FSM goes straight to PC_CLR (the receiver then runs off the end of memory).
- PC_CLR: one cycle of `pc_wren`=1, `pc_wdata`=0 → RUN.
- RUN: `go`=1. When `finish`=1 is sampled → RELEASE.
- RELEASE: `go`=0. When `finish`=0 is sampled → LEN_HI.
- ERR: `err`=1, `rx_ready`=0, no memory writes. `err_clr`=1 → LEN_HI and `err` clears.

Arithmetic and widths:
- LEN is 16-bit.
- The write pointer is ADDR_W+1 bits wide so the LEN=1024 end point is representable. `imem_waddr` is its low ADDR_W bits.

Boundary behaviour:
- Bytes presented while `rx_ready`=0 are not consumed; the source holds them.
- `finish` already high on entry to RUN (left over from an earlier run): the FSM still waits through RELEASE for it to go low. The receiver clears `finish` only while `go`=0.
- `rst_n`=0 in any state, including mid-DATA or RUN: next cycle the FSM is in LEN_HI and `go` drops. Memory contents already written are left as they are.

## Timing
- Values after reset: `rx_ready`=1, `imem_wren`=0, `imem_waddr`=0, `imem_wdata`=0, `pc_wren`=0, `pc_wdata`=0, `go`=0, `busy`=0, `err`=0.
- All outputs are registered.
- A transfer at edge k gives `imem_wren`/`imem_waddr`/`imem_wdata` valid during cycle k+1, held for exactly one cycle.
- Throughput in LEN_HI, LEN_LO, DATA and CSUM is one byte per cycle.
- From the CSUM transfer to `go` rising: 6 cycles with the terminator (4 TERM + 1 PC_CLR + 1 registered), 2 cycles when the terminator is skipped.
- `go` stays high from RUN entry until the cycle after `finish` is sampled high.
- `pc_wren` never coincides with `go`=1, so no PC write-port arbitration is needed against the receiver.

## Structure
- Shared package holds:
  - the state enum (LEN_HI, LEN_LO, DATA, CSUM, TERM, PC_CLR, RUN, RELEASE, ERR);
  - `IMEM_ADDR_W`=10 and `IMEM_DEPTH`=1024;
  - the terminator word constant `32'h00000000`, which must match the receiver's halt opcode.
- Single module. No sub-module is warranted; the checksum is one 8-bit accumulator register.

## Test plan
- Frame `00 04 11 22 33 44 AA`: bytes 11,22,33,44 written at 0–3, zeros at 4–7, one `pc_wren` with 0, then `go`=1. Drive `finish`=1 → `go`=0 next cycle; drop `finish` → back in LEN_HI with `rx_ready`=1.
- Frame `00 04 11 22 33 44 AB` (bad checksum): `err`=1, no terminator writes, `go` stays 0. Pulse `err_clr` → LEN_HI.
- Lengths `00 00`, `00 06` and `04 04`: each → ERR immediately after the second length byte, with no `imem_wren`.
- LEN=1024 with every byte `01`, CSUM=`00`: final write at address 1023, no TERM writes, `go` raised 2 cycles after the CSUM transfer.
- `rx_valid` toggling every other cycle during DATA: addresses still increment strictly 0,1,2,…; no duplicate or skipped writes.
- `rst_n`=0 while in RUN with `go`=1: `go`=0, `busy`=0, `rx_ready`=1 on the next cycle. A new valid frame then loads normally.
